// File: rtl/data_mem_access_unit.sv
// Splits each 16-bit big-endian load/store into two byte accesses on a byte-wide
// memory port with 1-cycle read latency; loads are reassembled before the response.
module data_mem_access_unit #(
   parameter int MEM_BYTES = 128,
   parameter int ADDR_W    = 16
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [15:0]       ReqWData,
   output logic              RespValid,
   output logic [15:0]       RespRData,
   output logic              AddrError,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [7:0]        MemWData,
   output logic              MemWrite,
   output logic              MemRead,
   input  logic [7:0]        MemRData
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BYTE0 = 3'd1,
      BYTE1 = 3'd2,
      CAPT  = 3'd3,
      RESP  = 3'd4
   } state_t;

   // Highest legal word address; anything above would make A+1 fall off the memory.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 2);

   state_t            state_q, state_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              err_q,   err_d;
   logic [15:0]       rdata_q, rdata_d;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      ReqReady  = 1'b0;
      RespValid = 1'b0;
      AddrError = 1'b0;
      MemAddr   = '0;
      MemWData  = '0;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;

      case (state_q)
         IDLE: begin
            ReqReady = 1'b1;
            if (ReqValid) begin
               write_d = ReqWrite;
               addr_d  = ReqAddr;
               wdata_d = ReqWData;
               if (ReqAddr > LAST_ADDR) begin
                  err_d   = 1'b1;
                  state_d = RESP;
                  // A rejected load still reports a defined (zero) word.
                  if (!ReqWrite) begin
                     rdata_d = '0;
                  end
               end else begin
                  err_d   = 1'b0;
                  state_d = BYTE0;
               end
            end
         end
         BYTE0: begin
            MemAddr = addr_q;
            if (write_q) begin
               MemWrite = 1'b1;
               MemWData = wdata_q[15:8];
            end else begin
               MemRead = 1'b1;
            end
            state_d = BYTE1;
         end
         BYTE1: begin
            MemAddr = addr_q + ADDR_W'(1);
            if (write_q) begin
               MemWrite = 1'b1;
               MemWData = wdata_q[7:0];
               state_d  = RESP;
            end else begin
               // MemRData now carries the high byte read in BYTE0.
               MemRead        = 1'b1;
               rdata_d[15:8]  = MemRData;
               state_d        = CAPT;
            end
         end
         CAPT: begin
            rdata_d[7:0] = MemRData;
            state_d      = RESP;
         end
         RESP: begin
            RespValid = 1'b1;
            AddrError = err_q;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign RespRData = rdata_q;

endmodule
